lru_update_unit: RTL
====================

# lru_update_unit

Read-modify-write controller for the 4-way cache's pseudo-ordered LRU state. It sits directly upstream of the 32-entry LRU storage array and owns that array's single index port, write strobe and write data. On each cache access it reads the set's 8-bit age ordering and reports the victim way. It then computes the new ordering with the accessed way promoted to MRU and writes it back on the following cycle.

## Interface
- INDEX_W, 5, set index width; the array holds 2**INDEX_W entries of 8 bits.

- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- access_valid  in  1  access request; sampled only while access_ready=1.
- access_ready  out  1  unit can accept an access this cycle.
- access_index  in  INDEX_W  set being accessed.
- access_way  in  2  way hit or filled by this access.
- victim_way  out  2  LRU way of access_index, valid while access_ready=1.
- update_done  out  1  one-cycle pulse when the write-back is issued.
- lru_index  out  INDEX_W  index driven to the array, used for both read and write.
- lru_rdata  in  8  combinational read data from the array at lru_index.
- lru_write  out  1  array write strobe.
- lru_wdata  out  8  new ordering written to the array.

## Operation
- Encoding: four 2-bit fields. [7:6]=MRU … [1:0]=LRU. The array's initial value is 8'b11100100, meaning MRU=3 and LRU=0.
- FSM states are IDLE and UPDATE.
- **IDLE**
  - access_ready=1.
  - lru_index=access_index.
  - victim_way=lru_rdata[1:0].
  - lru_write=0.
- **IDLE to UPDATE**, on access_valid:
  - Register access_index into idx_q and access_way into way_q.
  - Compute new_order from lru_rdata and register it into wdata_q.
- **new_order rule**
  - Find the slot k (3=MRU … 0=LRU) whose field equals way_q.
  - Fields in slots above k shift down one slot.
  - way_q is placed in [7:6].
  - Fields in slots below k are unchanged.
  - Example: 11100100 with way 0 gives 00111001.
  - If way_q is absent from all four fields (corrupt ordering), new_order is {way_q, then the remaining three ways in descending order}.
- **UPDATE**
  - access_ready=0.
  - lru_index=idx_q.
  - lru_write=1.
  - lru_wdata=wdata_q.
  - update_done=1.
  - Always returns to IDLE the next cycle.
- Throughput is one access per 2 cycles.
- victim_way in UPDATE holds its last IDLE value.

## Timing
- Reset (async assert) values:
  - state=IDLE.
  - idx_q=0, way_q=0, wdata_q=8'b11100100.
  - lru_write=0, update_done=0, access_ready=1.
  - lru_index=access_index and victim_way=lru_rdata[1:0], which are combinational in IDLE.
- Reset asserted during UPDATE: lru_write drops immediately and the write is lost. The ordering stays as before, which is acceptable.
- Cycle N: access accepted and victim_way valid.
- Cycle N+1: array write; the new value is visible on lru_rdata from cycle N+2.
- Back-to-back accesses to the same index need no bypass, because the next read happens after the write edge.
- access_valid while access_ready=0 is ignored. The requester must hold it.
- access_way is 2 bits and always in range; no wrap logic is needed.

## Configuration
- LRU_SKIP_MRU_WRITE_EN
  - Defined: if access_way already equals lru_rdata[7:6] in IDLE, the access is accepted with no transition to UPDATE. There is no write and no update_done, so the unit is ready again the next cycle.
  - Undefined: every accepted access goes through UPDATE and writes, even when the ordering is unchanged.

## Test plan
- Reset, then access index 5 way 0 with lru_rdata=11100100:
  - Cycle N: victim_way=0.
  - Cycle N+1: lru_write=1, lru_index=5, lru_wdata=00111001, update_done=1.
- Way 2 on 00111001 gives wdata 10001101. Way 1 on 10001101 gives 01100011.
- Access way 3 on 11100100:
  - Macro off: an UPDATE write of 11100100 occurs.
  - Macro on: no lru_write, and access_ready stays 1 for the next cycle.
- Corrupt lru_rdata=00000000 with way 2 gives wdata 10110100.
- Hold access_valid high for 6 cycles alternating indices 3 and 7:
  - Exactly 3 accepts and 3 writes.
  - access_ready toggles 1,0,1,0.
- Assert rst_n low mid-UPDATE:
  - lru_write falls within the same cycle.
  - After release, state is IDLE and access_ready=1.

Source files
------------

// File: rtl/lru_update_unit.sv
// rtl/lru_update_unit.sv - LRU ordering read-modify-write controller (option: LRU_SKIP_MRU_WRITE_EN)
module lru_update_unit #(
    parameter int INDEX_W = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               access_valid,
    output logic               access_ready,
    input  logic [INDEX_W-1:0] access_index,
    input  logic [1:0]         access_way,
    output logic [1:0]         victim_way,
    output logic               update_done,
    output logic [INDEX_W-1:0] lru_index,
    input  logic [7:0]         lru_rdata,
    output logic               lru_write,
    output logic [7:0]         lru_wdata
);

    typedef enum logic {IDLE, UPDATE} state_t;

    localparam logic [7:0] INIT_ORDER = 8'b11100100;

    state_t             state, state_nxt;
    logic [INDEX_W-1:0] idx_q;
    logic [7:0]         wdata_q;
    logic [1:0]         victim_q;
    logic               accept;
    logic               skip;
    logic [7:0]         new_order;

    // Promote way to MRU; the first matching slot from the MRU end wins, so a
    // partially corrupt ordering still yields a deterministic result.
    function automatic logic [7:0] promote(input logic [7:0] ord, input logic [1:0] way);
        logic [7:0] res;
        if (ord[7:6] == way)
            res = ord;
        else if (ord[5:4] == way)
            res = {way, ord[7:6], ord[3:0]};
        else if (ord[3:2] == way)
            res = {way, ord[7:4], ord[1:0]};
        else if (ord[1:0] == way)
            res = {way, ord[7:2]};
        else begin
            case (way)
                2'd0:    res = {2'd0, 2'd3, 2'd2, 2'd1};
                2'd1:    res = {2'd1, 2'd3, 2'd2, 2'd0};
                2'd2:    res = {2'd2, 2'd3, 2'd1, 2'd0};
                default: res = {2'd3, 2'd2, 2'd1, 2'd0};
            endcase
        end
        return res;
    endfunction

`ifdef LRU_SKIP_MRU_WRITE_EN
    assign skip = (access_way == lru_rdata[7:6]);
`else
    assign skip = 1'b0;
`endif

    assign accept    = (state == IDLE) && access_valid;
    assign new_order = promote(lru_rdata, access_way);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept && !skip) state_nxt = UPDATE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        access_ready = 1'b1;
        lru_index    = access_index;
        victim_way   = lru_rdata[1:0];
        lru_write    = 1'b0;
        update_done  = 1'b0;
        lru_wdata    = wdata_q;
        if (state == UPDATE) begin
            access_ready = 1'b0;
            lru_index    = idx_q;
            victim_way   = victim_q;
            lru_write    = 1'b1;
            update_done  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q    <= '0;
            wdata_q  <= INIT_ORDER;
            victim_q <= 2'd0;
        end else if (state == IDLE) begin
            victim_q <= lru_rdata[1:0];
            if (accept) begin
                idx_q   <= access_index;
                wdata_q <= new_order;
            end
        end
    end

endmodule
